sprite_mover: RTL and testbench
===============================

Name: sprite_mover

Overview:
- Parametrised successor to the single-block movement controller. Draws one square sprite over a background on the 640x480 VGA pipeline.
- Moves the sprite in 8 directions at a programmable rate derived from the pixel clock.
- Supports wrap or clamp at screen edges.
- Position changes are committed only at frame start, so a frame never shows a torn sprite. Sits between the display timing controller and the rgb output mux.

Parameters:
- X_MIN, 144, leftmost visible hCount (sprite centre lower bound).
- X_MAX, 783, rightmost visible hCount (centre upper bound).
- Y_MIN, 35, topmost visible vCount.
- Y_MAX, 514, bottommost visible vCount.
- X_RST, 450, reset centre x.
- Y_RST, 250, reset centre y.
- HALF, 5, half-size; sprite spans centre-HALF..centre+HALF (11x11 px).
- STEP, 1, pixels moved per move tick per axis.
- TICK_DIV, 250000, clk cycles per move tick (>=1).
- WRAP, 1, 1 = wrap to opposite edge; 0 = clamp at edge.
- COLOR, 12'hF00, sprite fill colour.
- Constraints: X_MIN>=HALF, Y_MIN>=HALF, X_MAX+HALF<1024, Y_MAX+HALF<1024.

Ports:
- clk  in  1  pixel clock; sole clock.
- rst  in  1  synchronous, active-high reset, sampled on rising clk.
- enable  in  1  1 = sprite drawn and movement active.
- bright  in  1  1 = inside display area.
- up, down, left, right  in  1 each  direction requests, level-sensitive.
- hCount, vCount  in  10 each  current pixel coordinates from timing controller.
- background  in  12  background pixel colour.
- rgb  out  12  registered pixel colour.
- sprite_on  out  1  registered; 1 when the pixel is inside the drawn sprite.
- xpos, ypos  out  10 each  committed (displayed) centre position.

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - tick_cnt=0.
  - shadow_x=xpos=X_RST, shadow_y=ypos=Y_RST.
  - rgb=12'h000, sprite_on=0.
  - Reset mid-frame or mid-tick discards any pending move.
- Tick counter:
  - tick_cnt counts 0..TICK_DIV-1 while enable=1.
  - move_tick=1 for exactly one cycle when tick_cnt==TICK_DIV-1; tick_cnt then returns to 0.
  - enable=0 holds tick_cnt.
- Motion, on move_tick only, updates shadow_x/shadow_y:
  - Axes are independent, so diagonal motion is legal.
  - up&down both 1: no y change. left&right both 1: no x change.
- Arithmetic is done in 11 bits, with no 10-bit overflow:
  - Right: if shadow_x+STEP > X_MAX, result is X_MIN (WRAP=1) or X_MAX (WRAP=0); else shadow_x+STEP.
  - Left: if shadow_x < X_MIN+STEP, result is X_MAX (WRAP=1) or X_MIN (WRAP=0); else shadow_x-STEP.
  - Down/up: same rules on y with Y_MIN/Y_MAX.
- Frame commit:
  - When hCount==0 && vCount==0, xpos<=shadow_x and ypos<=shadow_y.
  - If move_tick coincides with commit, the commit takes the pre-tick shadow value; the new value commits next frame.
  - Commit occurs regardless of enable.
- Hit test uses committed xpos/ypos: hit = hCount in [xpos-HALF, xpos+HALF] && vCount in [ypos-HALF, ypos+HALF], inclusive.
- Output, latency 1 clk from hCount/vCount/bright/background:
  - bright=0: rgb<=12'h000, sprite_on<=0.
  - bright=1, enable=1, hit=1: rgb<=COLOR, sprite_on<=1.
  - otherwise: rgb<=background, sprite_on<=0.

Optional Feature:
- Macro: SPRITE_OUTLINE_EN.
- Defined:
  - Pixels on the sprite perimeter (|hCount-xpos|==HALF or |vCount-ypos|==HALF) output 12'hFFF.
  - Interior pixels output COLOR.
  - sprite_on=1 for both.
- Undefined: the whole sprite is COLOR; no perimeter logic is synthesised.

Decomposition:
- Package vga_pkg:
  - Display bound constants H_VIS_START=144, H_VIS_END=783, V_VIS_START=35, V_VIS_END=514.
  - Colour constants BLACK, WHITE, RED.
  - A pixel_t 12-bit colour typedef.
- Sub-module tick_divider (parameter DIV; ports clk, rst, en, tick): holds the tick counter and is reused by future animated blocks.

Test Plan:
- Reset: rst=1 for 2 clk -> xpos=450, ypos=250, rgb=000, sprite_on=0; after release, tick_cnt starts at 0.
- Diagonal move: TICK_DIV=4, STEP=1, right=down=1 for 8 clk -> shadow=(452,252); xpos/ypos stay 450/250 until the hCount=vCount=0 commit, then read 452/252.
- Wrap: WRAP=1, shadow_x=783, right for 1 tick -> 144. Clamp: WRAP=0, shadow_x=783, right -> stays 783. Same pattern checked for y at 35/514.
- Opposing keys: left=right=1, up=1 for 1 tick from (450,250) -> (450,249).
- Draw: committed (450,250), bright=1, enable=1, hCount=455, vCount=245 -> next clk rgb=F00, sprite_on=1. hCount=456 -> rgb=background. bright=0 -> rgb=000.
- Enable low: enable=0 with right held for 20 clk -> no motion, tick_cnt frozen, rgb=background over the sprite area; raising enable resumes the count from its held value.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480 VGA display constants, colour type and sprite coordinate helper.
package vga_pkg;

  localparam int unsigned H_VIS_START = 144;
  localparam int unsigned H_VIS_END   = 783;
  localparam int unsigned V_VIS_START = 35;
  localparam int unsigned V_VIS_END   = 514;

  typedef logic [11:0] pixel_t;

  localparam pixel_t BLACK = 12'h000;
  localparam pixel_t WHITE = 12'hFFF;
  localparam pixel_t RED   = 12'hF00;

  // One axis step in 11 bits so pos+st never wraps before the bound compare.
  function automatic logic [10:0] next_coord(
    input logic [10:0] pos,
    input logic        inc,
    input logic        dec,
    input logic [10:0] lo,
    input logic [10:0] hi,
    input logic [10:0] st,
    input logic        wrap
  );
    logic [10:0] r;
    r = pos;
    if (inc && !dec) begin
      if (pos + st > hi) r = wrap ? lo : hi;
      else               r = pos + st;
    end else if (dec && !inc) begin
      if (pos < lo + st) r = wrap ? hi : lo;
      else               r = pos - st;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick every DIV enabled clocks; count holds while en=0.
module tick_divider #(
  parameter int unsigned DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sprite_mover.sv
// Square sprite over background with 8-way motion, wrap/clamp edges and frame-start commit.
// Optional perimeter highlight when SPRITE_OUTLINE_EN is defined.
module sprite_mover
  import vga_pkg::*;
#(
  parameter int unsigned X_MIN    = H_VIS_START,
  parameter int unsigned X_MAX    = H_VIS_END,
  parameter int unsigned Y_MIN    = V_VIS_START,
  parameter int unsigned Y_MAX    = V_VIS_END,
  parameter int unsigned X_RST    = 450,
  parameter int unsigned Y_RST    = 250,
  parameter int unsigned HALF     = 5,
  parameter int unsigned STEP     = 1,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned WRAP     = 1,
  parameter pixel_t      COLOR    = RED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        bright,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [11:0] background,
  output logic [11:0] rgb,
  output logic        sprite_on,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos
);

  localparam logic [10:0] X_MIN11 = 11'(X_MIN);
  localparam logic [10:0] X_MAX11 = 11'(X_MAX);
  localparam logic [10:0] Y_MIN11 = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX11 = 11'(Y_MAX);
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] HALF11  = 11'(HALF);
  localparam logic        WRAP_EN = (WRAP != 0);

  logic        move_tick;
  logic [9:0]  shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic [9:0]  xpos_q, xpos_d, ypos_q, ypos_d;
  pixel_t      rgb_q, rgb_d;
  logic        sprite_on_q, sprite_on_d;

  logic [10:0] h11, v11, x11, y11;
  logic        frame_start, hit;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .tick (move_tick)
  );

  assign h11         = {1'b0, hCount};
  assign v11         = {1'b0, vCount};
  assign x11         = {1'b0, xpos_q};
  assign y11         = {1'b0, ypos_q};
  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
  assign hit = (h11 >= x11 - HALF11) && (h11 <= x11 + HALF11) &&
               (v11 >= y11 - HALF11) && (v11 <= y11 + HALF11);

`ifdef SPRITE_OUTLINE_EN
  logic perim;
  assign perim = (h11 == x11 - HALF11) || (h11 == x11 + HALF11) ||
                 (v11 == y11 - HALF11) || (v11 == y11 + HALF11);
`endif

  // Commit samples the pre-tick shadow, so a coincident move lands next frame.
  always_comb begin
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    rgb_d       = BLACK;
    sprite_on_d = 1'b0;

    if (move_tick) begin
      shadow_x_d = 10'(next_coord({1'b0, shadow_x_q}, right, left,
                                  X_MIN11, X_MAX11, STEP11, WRAP_EN));
      shadow_y_d = 10'(next_coord({1'b0, shadow_y_q}, down, up,
                                  Y_MIN11, Y_MAX11, STEP11, WRAP_EN));
    end

    if (frame_start) begin
      xpos_d = shadow_x_q;
      ypos_d = shadow_y_q;
    end

    if (bright) begin
      if (enable && hit) begin
        sprite_on_d = 1'b1;
`ifdef SPRITE_OUTLINE_EN
        rgb_d = perim ? WHITE : COLOR;
`else
        rgb_d = COLOR;
`endif
      end else begin
        rgb_d = background;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x_q  <= 10'(X_RST);
      shadow_y_q  <= 10'(Y_RST);
      xpos_q      <= 10'(X_RST);
      ypos_q      <= 10'(Y_RST);
      rgb_q       <= BLACK;
      sprite_on_q <= 1'b0;
    end else begin
      shadow_x_q  <= shadow_x_d;
      shadow_y_q  <= shadow_y_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      rgb_q       <= rgb_d;
      sprite_on_q <= sprite_on_d;
    end
  end

  assign rgb       = rgb_q;
  assign sprite_on = sprite_on_q;
  assign xpos      = xpos_q;
  assign ypos      = ypos_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: wrap and clamp instances against a per-cycle behavioural model.
module tb_sprite_mover;

  localparam int DIV  = 4;
  localparam int XMIN = 144, XMAX = 783, YMIN = 35, YMAX = 514;
  localparam int HALF = 5;
  localparam logic [11:0] SPR = 12'hF00;

  logic        clk = 1'b0;
  logic        rst, enable, bright, up, down, left, right;
  logic [9:0]  hCount, vCount;
  logic [11:0] background;
  logic [11:0] rgb_w, rgb_c;
  logic        on_w, on_c;
  logic [9:0]  xpos_w, ypos_w, xpos_c, ypos_c;

  always #5 clk = ~clk;

  sprite_mover #(.TICK_DIV(DIV), .STEP(1), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .enable(enable), .bright(bright),
    .up(up), .down(down), .left(left), .right(right),
    .hCount(hCount), .vCount(vCount), .background(background),
    .rgb(rgb_w), .sprite_on(on_w), .xpos(xpos_w), .ypos(ypos_w));

  sprite_mover #(.TICK_DIV(DIV), .STEP(1), .WRAP(0)) dut_clamp (
    .clk(clk), .rst(rst), .enable(enable), .bright(bright),
    .up(up), .down(down), .left(left), .right(right),
    .hCount(hCount), .vCount(vCount), .background(background),
    .rgb(rgb_c), .sprite_on(on_c), .xpos(xpos_c), .ypos(ypos_c));

  // Model state; index 1 = wrap instance, index 0 = clamp instance.
  int          m_cnt;
  int          sx[2], sy[2], cx[2], cy[2];
  logic [11:0] e_rgb[2];
  logic        e_on[2];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mv(int p, logic inc, logic dec, int lo, int hi, bit wrap);
    if (inc && !dec) return (p + 1 > hi) ? (wrap ? lo : hi) : p + 1;
    if (dec && !inc) return (p - 1 < lo) ? (wrap ? hi : lo) : p - 1;
    return p;
  endfunction

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_edge();
    bit tk;
    int h, v;
    h = int'(hCount);
    v = int'(vCount);
    if (rst) begin
      m_cnt = 0;
      for (int w = 0; w < 2; w++) begin
        sx[w] = 450; sy[w] = 250; cx[w] = 450; cy[w] = 250;
        e_rgb[w] = 12'h000; e_on[w] = 1'b0;
      end
    end else begin
      tk = enable && (m_cnt == DIV - 1);
      for (int w = 0; w < 2; w++) begin
        if (!bright) begin
          e_rgb[w] = 12'h000; e_on[w] = 1'b0;
        end else if (enable && iabs(h - cx[w]) <= HALF && iabs(v - cy[w]) <= HALF) begin
          e_on[w]  = 1'b1;
          e_rgb[w] = SPR;
`ifdef SPRITE_OUTLINE_EN
          if (iabs(h - cx[w]) == HALF || iabs(v - cy[w]) == HALF) e_rgb[w] = 12'hFFF;
`endif
        end else begin
          e_rgb[w] = background; e_on[w] = 1'b0;
        end
        if (h == 0 && v == 0) begin
          cx[w] = sx[w]; cy[w] = sy[w];
        end
        if (tk) begin
          sx[w] = mv(sx[w], right, left, XMIN, XMAX, w == 1);
          sy[w] = mv(sy[w], down, up, YMIN, YMAX, w == 1);
        end
      end
      if (enable) m_cnt = tk ? 0 : m_cnt + 1;
    end
  endtask

  task automatic check_all();
    chk("xpos_wrap", 32'(xpos_w), 32'(cx[1]));
    chk("ypos_wrap", 32'(ypos_w), 32'(cy[1]));
    chk("rgb_wrap",  32'(rgb_w),  32'(e_rgb[1]));
    chk("on_wrap",   32'(on_w),   32'(e_on[1]));
    chk("xpos_clamp", 32'(xpos_c), 32'(cx[0]));
    chk("ypos_clamp", 32'(ypos_c), 32'(cy[0]));
    chk("rgb_clamp",  32'(rgb_c),  32'(e_rgb[0]));
    chk("on_clamp",   32'(on_c),   32'(e_on[0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Random non-origin raster position with random brightness and background.
  task automatic rand_pix();
    hCount     = 10'($urandom_range(799, 1));
    vCount     = 10'($urandom_range(524, 1));
    bright     = 1'($urandom);
    background = 12'($urandom);
  endtask

  task automatic commit();
    {up, down, left, right} = 4'b0000;
    hCount = 10'd0; vCount = 10'd0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; bright = 1'b0;
    {up, down, left, right} = 4'b0000;
    hCount = 10'd10; vCount = 10'd10; background = 12'h0A5;
    @(negedge clk);

    // Reset values
    do_reset();
    chk("rst_xpos", 32'(xpos_w), 32'd450);
    chk("rst_ypos", 32'(ypos_w), 32'd250);
    chk("rst_rgb",  32'(rgb_w),  32'h000);
    chk("rst_on",   32'(on_w),   32'd0);

    // Diagonal move: two ticks in 8 clocks, visible only after commit
    enable = 1'b1; right = 1'b1; down = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_pix(); cyc(); end
    chk("diag_precommit_x", 32'(xpos_w), 32'd450);
    chk("diag_precommit_y", 32'(ypos_w), 32'd250);
    commit();
    chk("diag_x", 32'(xpos_w), 32'd452);
    chk("diag_y", 32'(ypos_w), 32'd252);

    // Opposing horizontal keys cancel, up still applies
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_pix(); left = 1'b1; right = 1'b1; up = 1'b1; cyc();
    end
    commit();
    chk("oppose_x", 32'(xpos_w), 32'd450);
    chk("oppose_y", 32'(ypos_w), 32'd249);

    // Right edge: drive to 783 then one more tick
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 2000 && sx[0] != XMAX; i++) begin rand_pix(); right = 1'b1; cyc(); end
    commit();
    chk("edge_x_wrap_at_max",  32'(xpos_w), 32'd783);
    chk("edge_x_clamp_at_max", 32'(xpos_c), 32'd783);
    for (int i = 0; i < DIV; i++) begin rand_pix(); right = 1'b1; cyc(); end
    commit();
    chk("wrap_x_right",  32'(xpos_w), 32'd144);
    chk("clamp_x_right", 32'(xpos_c), 32'd783);

    // Bottom edge
    for (int i = 0; i < 2000 && sy[0] != YMAX; i++) begin rand_pix(); down = 1'b1; cyc(); end
    commit();
    chk("edge_y_clamp_at_max", 32'(ypos_c), 32'd514);
    for (int i = 0; i < DIV; i++) begin rand_pix(); down = 1'b1; cyc(); end
    commit();
    chk("wrap_y_down",  32'(ypos_w), 32'd35);
    chk("clamp_y_down", 32'(ypos_c), 32'd514);

    // Top edge on the clamp instance
    for (int i = 0; i < 3000 && sy[0] != YMIN; i++) begin rand_pix(); up = 1'b1; cyc(); end
    for (int i = 0; i < DIV; i++) begin rand_pix(); up = 1'b1; cyc(); end
    commit();
    chk("clamp_y_up", 32'(ypos_c), 32'd35);

    // Draw at committed (450,250)
    do_reset();
    enable = 1'b1; commit();
    bright = 1'b1; background = 12'h3C7; hCount = 10'd455; vCount = 10'd245;
    cyc();
`ifdef SPRITE_OUTLINE_EN
    chk("draw_corner_rgb", 32'(rgb_w), 32'hFFF);
`else
    chk("draw_corner_rgb", 32'(rgb_w), 32'hF00);
`endif
    chk("draw_corner_on", 32'(on_w), 32'd1);
    hCount = 10'd456; cyc();
    chk("draw_outside_rgb", 32'(rgb_w), 32'h3C7);
    chk("draw_outside_on",  32'(on_w),  32'd0);
    hCount = 10'd450; bright = 1'b0; cyc();
    chk("draw_dark_rgb", 32'(rgb_w), 32'h000);

    // Enable low freezes the divider mid-count and hides the sprite
    for (int i = 0; i < DIV && m_cnt != 2; i++) begin rand_pix(); cyc(); end
    enable = 1'b0; right = 1'b1; bright = 1'b1; background = 12'h5A5;
    hCount = 10'd450; vCount = 10'd250;
    for (int i = 0; i < 20; i++) cyc();
    chk("disabled_rgb", 32'(rgb_w), 32'h5A5);
    chk("disabled_on",  32'(on_w),  32'd0);
    enable = 1'b1;
    cyc(); cyc();
    commit();
    chk("resume_x", 32'(xpos_w), 32'd451);

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(199, 0) == 0);
      enable = ($urandom_range(3, 0) != 0);
      {up, down, left, right} = 4'($urandom);
      bright     = 1'($urandom);
      background = 12'($urandom);
      case ($urandom_range(7, 0))
        0:       begin hCount = 10'd0; vCount = 10'd0; end
        1, 2, 3: begin
          hCount = 10'(cx[1] + $urandom_range(16, 0) - 8);
          vCount = 10'(cy[1] + $urandom_range(16, 0) - 8);
        end
        default: begin
          hCount = 10'($urandom_range(799, 0));
          vCount = 10'($urandom_range(524, 0));
        end
      endcase
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
